// File: rtl/adder_operand_stager.sv
// adder_operand_stager
//   Operand feeder for the 12-bit Brent-Kung adder. Operand pairs (A,B) come in
//   on a valid/ready handshake and are held in a 2-entry skid FIFO. The head
//   entry is driven onto the adder's interleaved operand bus
//   (bus[2i]=A[i], bus[2i+1]=B[i]).
//   in_ready depends only on registered state, so the ready path between the
//   operand source and the adder-side consumer is broken.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair present          in_ready   stager can accept
//   in_a/in_b  operands (WIDTH)
//   out_valid  out_bus holds a pair          out_ready  consumer takes pair
//   out_bus    interleaved operands (2*WIDTH), zero when empty
//   occupancy  entries held (0..2)
//   xfer_cnt   pairs delivered since reset, wraps modulo 2^CNT_W
module adder_operand_stager #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     xfer_cnt
);

  // Entries are stored raw as {B,A}; interleaving happens only at the output mux.
  logic [1:0][2*WIDTH-1:0] r_mem;
  logic                    r_rd;
  logic                    r_wr;
  logic [1:0]              r_occ;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_push;
  logic                    w_pop;
  logic [2*WIDTH-1:0]      w_head;
  logic [2*WIDTH-1:0]      w_bus;

  assign in_ready  = ~rst & (r_occ != 2'd2);
  assign out_valid = (r_occ != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_mem[r_rd];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ilv
    assign w_bus[2*i]   = w_head[i];
    assign w_bus[2*i+1] = w_head[WIDTH+i];
  end

  assign out_bus   = out_valid ? w_bus : '0;
  assign occupancy = r_occ;
  assign xfer_cnt  = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_occ <= 2'd0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {in_b, in_a};
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd  <= ~r_rd;
        r_cnt <= r_cnt + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_operand_stager.sv
module tb_adder_operand_stager;
  localparam int WIDTH = 12;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a = '0;
  logic [WIDTH-1:0]   in_b = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [2*WIDTH-1:0] out_bus;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   xfer_cnt;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  adder_operand_stager #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_bus(out_bus), .occupancy(occupancy), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Outputs depend only on registered state, so sampling 2ns after the edge is stable.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [2*WIDTH-1:0] ilv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  // What the adder netlist produces from the bus: {carry,sum}.
  function automatic logic [WIDTH:0] adder_of(input logic [2*WIDTH-1:0] bus);
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < WIDTH; i++) begin
      a[i] = bus[2*i];
      b[i] = bus[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic test_reset();
    tick(); tick();
    total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (occupancy !== 2'd0)  begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
    total++; if (xfer_cnt !== 16'd0)  begin bad++; $display("FAIL rst_cnt got=%0d want=0", xfer_cnt); end
    total++; if (out_bus !== 24'd0)   begin bad++; $display("FAIL rst_bus got=%h want=0", out_bus); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_first();
    in_valid = 1'b1; in_a = 12'h0FF; in_b = 12'h001; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1)     begin bad++; $display("FAIL first_valid got=%b want=1", out_valid); end
    total++; if (out_bus !== 24'h005557) begin bad++; $display("FAIL first_bus got=%h want=005557", out_bus); end
    total++; if (adder_of(out_bus) !== 13'h0100) begin bad++; $display("FAIL first_sum got=%h want=0100", adder_of(out_bus)); end
    total++; if (xfer_cnt !== 16'd0)     begin bad++; $display("FAIL first_cnt_pre got=%0d want=0", xfer_cnt); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    out_ready = 1'b0;
    total++; if (occupancy !== 2'd0)     begin bad++; $display("FAIL first_occ got=%0d want=0", occupancy); end
    total++; if (xfer_cnt !== 16'd1)     begin bad++; $display("FAIL first_cnt got=%0d want=1", xfer_cnt); end
    total++; if (out_bus !== 24'd0)      begin bad++; $display("FAIL first_empty_bus got=%h want=0", out_bus); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 12'hABC; in_b = 12'h123;
    tick();
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL full_occ1 got=%0d want=1", occupancy); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL full_rdy1 got=%b want=1", in_ready); end
    in_a = 12'h456; in_b = 12'h789;
    tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL full_occ2 got=%0d want=2", occupancy); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL full_rdy2 got=%b want=0", in_ready); end
    in_a = 12'hFFF; in_b = 12'hFFF;
    tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL full_occ3 got=%0d want=2", occupancy); end
    total++; if (out_bus !== ilv(12'hABC, 12'h123)) begin bad++; $display("FAIL full_hold got=%h want=%h", out_bus, ilv(12'hABC, 12'h123)); end
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    total++; if (out_bus !== ilv(12'h456, 12'h789)) begin bad++; $display("FAIL full_second got=%h want=%h", out_bus, ilv(12'h456, 12'h789)); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    out_ready = 1'b0;
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL full_drain got=%0d want=0", occupancy); end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL full_cnt got=%0d want=%0d", xfer_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] pa, pb;
    in_valid = 1'b1; in_a = 12'h100; in_b = 12'h200; out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      pa = 12'h100 + 12'(k - 1); pb = 12'h200 + 12'(k - 1);
      total++; if (out_bus !== ilv(pa, pb)) begin bad++; $display("FAIL b2b_order k=%0d got=%h want=%h", k, out_bus, ilv(pa, pb)); end
      in_a = 12'h100 + 12'(k); in_b = 12'h200 + 12'(k);
      tick();
      exp_cnt = exp_cnt + 1'b1;
      total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL b2b_occ k=%0d got=%0d want=1", k, occupancy); end
    end
    in_valid = 1'b0;
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", xfer_cnt, exp_cnt); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_a = 12'h321; in_b = 12'h654; out_ready = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL mid_pre_occ got=%0d want=2", occupancy); end
    #1 rst = 1'b1;
    #1;
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL mid_occ got=%0d want=0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
    total++; if (out_bus !== 24'd0)  begin bad++; $display("FAIL mid_bus got=%h want=0", out_bus); end
    total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL mid_rdy got=%b want=0", in_ready); end
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    tick();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_rel_rdy got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_valid got=%b want=0", out_valid); end
    total++; if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL mid_rel_cnt got=%0d want=0", xfer_cnt); end
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; in_a = 12'h001; in_b = 12'h002; out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 65535; k++) tick();
    total++; if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", xfer_cnt); end
    total++; if (occupancy !== 2'd1)    begin bad++; $display("FAIL wrap_occ got=%0d want=1", occupancy); end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", xfer_cnt); end
    exp_cnt = '0;
  endtask

  task automatic test_random();
    logic [2*WIDTH-1:0] q[$];
    logic [11:0] ra, rb;
    logic iv, orr;
    int errs;
    errs = 0;
    for (int c = 0; c < 10000; c++) begin
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() != 0)) begin
        errs++;
        if (errs < 5) $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, occupancy, q.size());
      end
      iv = 1'($urandom_range(0, 1)); orr = 1'($urandom_range(0, 1));
      ra = 12'($urandom); rb = 12'($urandom);
      in_valid = iv; in_a = ra; in_b = rb; out_ready = orr;
      #1;
      if (out_valid && orr && q.size() != 0) begin
        if (out_bus !== q[0] || adder_of(out_bus) !== adder_of(q[0])) begin
          errs++;
          if (errs < 5) $display("FAIL rnd_pop c=%0d got=%h want=%h", c, out_bus, q[0]);
        end
        void'(q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (iv && in_ready) q.push_back({rb, ra} == 24'd0 ? 24'd0 : ilv(ra, rb));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL rnd_scoreboard errors=%0d want=0", errs); end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL rnd_cnt got=%0d want=%0d", xfer_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_first();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
